// File: rtl/vtg_pkg.sv
// Shared definitions for the raster timing generator: FSM encodings, 640x480@60
// default timing and helpers for line/frame totals and sync window bounds.
package vtg_pkg;

  typedef logic [1:0] vtg_state_t;

  localparam vtg_state_t StIdle  = 2'd0;
  localparam vtg_state_t StRun   = 2'd1;
  localparam vtg_state_t StDrain = 2'd2;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  function automatic int unsigned vtg_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned vtg_sync_start(input int unsigned active,
                                                 input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned vtg_sync_end(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vtg_axis.sv
// One raster axis: position counter with advance/clear/wrap-out and decode of the
// active and sync regions for the count being loaded this cycle.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int unsigned CW     = 12,
  parameter int unsigned TOTAL  = 800,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter bit          POL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam logic [CW-1:0] Last    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ActEnd  = CW'(ACTIVE);
  localparam logic [CW-1:0] SyncBeg = CW'(vtg_sync_start(ACTIVE, FP));
  localparam logic [CW-1:0] SyncEnd = CW'(vtg_sync_end(ACTIVE, FP, SYNC));

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap = adv && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

  // Decoding the next count lets the parent register these alongside cnt.
  assign active = (cnt_d < ActEnd);
  assign sync   = ((cnt_d >= SyncBeg) && (cnt_d < SyncEnd)) ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Progressive raster timing generator with pixel clock-enable divider and
// frame-aligned start/stop. Define VTG_FRAME_CNT_EN to add the frame counter.
module video_timing_gen
  import vtg_pkg::*;
#(
`ifdef VTG_FRAME_CNT_EN
  parameter int unsigned FCW      = 16,
`endif
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CW       = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic           pix_ce,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic           sol,
  output logic           sof,
`ifdef VTG_FRAME_CNT_EN
  output logic [FCW-1:0] frame_cnt,
`endif
  output logic           busy
);

  localparam int unsigned HTotal = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          tick;
  vtg_state_t    state_q, state_d;
  logic          pix_ce_q, de_q, hsync_q, vsync_q, sol_q, sof_q;
  logic          start, run_d, cnt_adv, cnt_clr;
  logic          h_wrap, h_act, h_sync;
  logic          v_wrap, v_act, v_sync;
  logic          sol_d, sof_d;

  // tick marks the edge on which pix_ce rises; all raster state moves there.
  assign tick   = (dcnt_q == DivLast);
  assign dcnt_d = tick ? '0 : dcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        StIdle:  if (en) state_d = StRun;
        StRun:   if (!en) state_d = StDrain;
        StDrain: begin
          if (en) begin
            state_d = StRun;
          end else if (v_wrap) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign start   = tick && (state_q == StIdle) && en;
  assign run_d   = (state_d != StIdle);
  assign cnt_adv = tick && (state_q != StIdle);
  assign cnt_clr = tick && !run_d;

  vtg_axis #(
    .CW     (CW),
    .TOTAL  (HTotal),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .adv    (cnt_adv),
    .clr    (cnt_clr),
    .cnt    (x),
    .wrap   (h_wrap),
    .active (h_act),
    .sync   (h_sync)
  );

  vtg_axis #(
    .CW     (CW),
    .TOTAL  (VTotal),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .adv    (h_wrap),
    .clr    (cnt_clr),
    .cnt    (y),
    .wrap   (v_wrap),
    .active (v_act),
    .sync   (v_sync)
  );

  // A drain ending at the last pixel returns to (0,0) silently.
  assign sol_d = start || (h_wrap && run_d);
  assign sof_d = start || (v_wrap && run_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dcnt_q   <= '0;
      pix_ce_q <= 1'b0;
      state_q  <= StIdle;
      de_q     <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      sol_q    <= 1'b0;
      sof_q    <= 1'b0;
    end else begin
      dcnt_q   <= dcnt_d;
      pix_ce_q <= tick;
      state_q  <= state_d;
      de_q     <= run_d && h_act && v_act;
      hsync_q  <= run_d ? h_sync : ~HS_POL;
      vsync_q  <= run_d ? v_sync : ~VS_POL;
      sol_q    <= sol_d;
      sof_q    <= sof_d;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [FCW-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (sof_d) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pix_ce = pix_ce_q;
  assign de     = de_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign sol    = sol_q;
  assign sof    = sof_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 640x480 mode, a tiny active-high
// mode at CLK_DIV=1, and a tiny mode exercising drain, restart and reset.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_a, en_b, en_c;

  logic        pce_a, de_a, hs_a, vs_a, sol_a, sof_a, busy_a;
  logic [11:0] x_a, y_a;
  logic        pce_b, de_b, hs_b, vs_b, sol_b, sof_b, busy_b;
  logic [11:0] x_b, y_b;
  logic        pce_c, de_c, hs_c, vs_c, sol_c, sof_c, busy_c;
  logic [11:0] x_c, y_c;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
  logic [1:0]  fc_c;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  video_timing_gen dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en_a),
    .pix_ce    (pce_a),
    .x         (x_a),
    .y         (y_a),
    .de        (de_a),
    .hsync     (hs_a),
    .vsync     (vs_a),
    .sol       (sol_a),
    .sof       (sof_a),
`ifdef VTG_FRAME_CNT_EN
    .frame_cnt (fc_a),
`endif
    .busy      (busy_a)
  );

  video_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b1), .CLK_DIV (1)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en_b),
    .pix_ce    (pce_b),
    .x         (x_b),
    .y         (y_b),
    .de        (de_b),
    .hsync     (hs_b),
    .vsync     (vs_b),
    .sol       (sol_b),
    .sof       (sof_b),
`ifdef VTG_FRAME_CNT_EN
    .frame_cnt (fc_b),
`endif
    .busy      (busy_b)
  );

  video_timing_gen #(
`ifdef VTG_FRAME_CNT_EN
    .FCW      (2),
`endif
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0), .CLK_DIV (2)
  ) dut_c (
    .clk       (clk),
    .rst       (rst),
    .en        (en_c),
    .pix_ce    (pce_c),
    .x         (x_c),
    .y         (y_c),
    .de        (de_c),
    .hsync     (hs_c),
    .vsync     (vs_c),
    .sol       (sol_c),
    .sof       (sof_c),
`ifdef VTG_FRAME_CNT_EN
    .frame_cnt (fc_c),
`endif
    .busy      (busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_rst(input string tag, input logic pce, input logic [11:0] xv,
                         input logic [11:0] yv, input logic dev, input logic hs,
                         input logic vs, input logic so_l, input logic so_f,
                         input logic bsy, input logic hs_idle, input logic vs_idle);
    chk({tag, "_pce"}, pce, 1'b0);
    chk({tag, "_x"}, xv, 12'd0);
    chk({tag, "_y"}, yv, 12'd0);
    chk({tag, "_de"}, dev, 1'b0);
    chk({tag, "_hs"}, hs, hs_idle);
    chk({tag, "_vs"}, vs, vs_idle);
    chk({tag, "_sol"}, so_l, 1'b0);
    chk({tag, "_sof"}, so_f, 1'b0);
    chk({tag, "_busy"}, bsy, 1'b0);
  endtask

  // Step to the n-th following pix_ce of dut_c, bounded so a dead divider cannot hang.
  task automatic adv_c(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!pce_c && g < 8);
      if (!pce_c) chk("c_pce_timeout", pce_c, 1'b1);
    end
  endtask

  task automatic pos_c(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, x_c, ex);
    chk({tag, "_y"}, y_c, ey);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ex, ey, pn, last_sol;
    bit  seen_sol, pe;

    rst  = 1'b0;
    en_a = 1'b1;
    en_b = 1'b0;
    en_c = 1'b0;
    repeat (5) @(negedge clk);
    chk_rst("a_rst", pce_a, x_a, y_a, de_a, hs_a, vs_a, sol_a, sof_a, busy_a, 1'b1, 1'b1);
    chk_rst("b_rst", pce_b, x_b, y_b, de_b, hs_b, vs_b, sol_b, sof_b, busy_b, 1'b0, 1'b0);
`ifdef VTG_FRAME_CNT_EN
    chk("a_rst_fc", fc_a, 16'd0);
`endif

    // Default 640x480 mode: first pix_ce two clocks after release, one line and a bit.
    rst      = 1'b1;
    ex       = 0;
    ey       = 0;
    pn       = 0;
    last_sol = 0;
    seen_sol = 1'b0;
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      pe = (c % 2 == 0);
      if (pe && c > 2) begin
        ex++;
        if (ex == 800) begin
          ex = 0;
          ey++;
        end
      end
      chk("a_pce", pce_a, pe);
      if (c >= 2) begin
        chk("a_x", x_a, ex);
        chk("a_y", y_a, ey);
        chk("a_de", de_a, (ex < 640) && (ey < 480));
        chk("a_hs", hs_a, !((ex >= 656) && (ex < 752)));
        chk("a_vs", vs_a, !((ey >= 490) && (ey < 492)));
        chk("a_sol", sol_a, pe && (ex == 0));
        chk("a_sof", sof_a, c == 2);
        chk("a_busy", busy_a, 1'b1);
      end else begin
        chk("a_busy0", busy_a, 1'b0);
      end
`ifdef VTG_FRAME_CNT_EN
      if (c == 2) chk("a_fc", fc_a, 16'd1);
`endif
      if (pce_a) pn++;
      if (sol_a) begin
        if (seen_sol) chk("a_line_pce", pn - last_sol, 800);
        last_sol = pn;
        seen_sol = 1'b1;
      end
    end
    chk("a_line_seen", seen_sol, 1'b1);

    // Mid-line reset of the default instance.
    rst = 1'b0;
    @(negedge clk);
    chk_rst("a_mid", pce_a, x_a, y_a, de_a, hs_a, vs_a, sol_a, sof_a, busy_a, 1'b1, 1'b1);
    chk_rst("b_mid", pce_b, x_b, y_b, de_b, hs_b, vs_b, sol_b, sof_b, busy_b, 1'b0, 1'b0);

    // Tiny active-high mode, pix_ce every clock, 14x7 = 98 clocks per frame.
    en_a = 1'b0;
    en_b = 1'b1;
    rst  = 1'b1;
    ex   = 0;
    ey   = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c > 1) begin
        ex++;
        if (ex == 14) begin
          ex = 0;
          ey = (ey == 6) ? 0 : ey + 1;
        end
      end
      chk("b_pce", pce_b, 1'b1);
      chk("b_x", x_b, ex);
      chk("b_y", y_b, ey);
      chk("b_de", de_b, (ex < 8) && (ey < 4));
      chk("b_hs", hs_b, (ex >= 10) && (ex < 12));
      chk("b_vs", vs_b, ey == 5);
      chk("b_sol", sol_b, ex == 0);
      chk("b_sof", sof_b, (c % 98) == 1);
    end
    chk("a_idle_busy", busy_a, 1'b0);

    // Tiny active-low mode at CLK_DIV=2: drain, re-enable, frame count, reset.
    rst  = 1'b0;
    en_b = 1'b0;
    @(negedge clk);
    chk_rst("c_rst", pce_c, x_c, y_c, de_c, hs_c, vs_c, sol_c, sof_c, busy_c, 1'b1, 1'b1);
    rst  = 1'b1;
    en_c = 1'b1;
    @(negedge clk);
    chk("c_pce1", pce_c, 1'b0);
    @(negedge clk);
    chk("c_pce2", pce_c, 1'b1);
    chk("c_sof0", sof_c, 1'b1);
    chk("c_sol0", sol_c, 1'b1);
    pos_c("c_k0", 0, 0);
    chk("c_de0", de_c, 1'b1);
`ifdef VTG_FRAME_CNT_EN
    chk("c_fc1", fc_c, 2'd1);
`endif
    adv_c(28);
    pos_c("c_k28", 0, 2);
    en_c = 1'b0;
    adv_c(69);
    pos_c("c_k97", 13, 6);
    chk("c_k97_busy", busy_c, 1'b1);
    adv_c(1);
    chk_rst("c_idle", 1'b0, x_c, y_c, de_c, hs_c, vs_c, sol_c, sof_c, busy_c, 1'b1, 1'b1);
    chk("c_idle_pce", pce_c, 1'b1);
    adv_c(3);
    chk("c_idle2_busy", busy_c, 1'b0);
    chk("c_idle2_sof", sof_c, 1'b0);
`ifdef VTG_FRAME_CNT_EN
    chk("c_idle_fc", fc_c, 2'd1);
`endif

    en_c = 1'b1;
    adv_c(1);
    chk("c_m0_sof", sof_c, 1'b1);
    chk("c_m0_sol", sol_c, 1'b1);
    pos_c("c_m0", 0, 0);
    chk("c_m0_busy", busy_c, 1'b1);
`ifdef VTG_FRAME_CNT_EN
    chk("c_fc2", fc_c, 2'd2);
`endif
    adv_c(28);
    en_c = 1'b0;
    adv_c(1);
    pos_c("c_m29", 1, 2);
    chk("c_m29_busy", busy_c, 1'b1);
    adv_c(27);
    pos_c("c_m56", 0, 4);
    en_c = 1'b1;
    adv_c(1);
    pos_c("c_m57", 1, 4);
    adv_c(9);
    pos_c("c_m66", 10, 4);
    chk("c_m66_hs", hs_c, 1'b0);
    chk("c_m66_de", de_c, 1'b0);
    adv_c(2);
    chk("c_m68_hs", hs_c, 1'b1);
    adv_c(2);
    pos_c("c_m70", 0, 5);
    chk("c_m70_vs", vs_c, 1'b0);
    chk("c_m70_sol", sol_c, 1'b1);
    adv_c(27);
    pos_c("c_m97", 13, 6);
    chk("c_m97_vs", vs_c, 1'b1);
    chk("c_m97_sof", sof_c, 1'b0);
    adv_c(1);
    chk("c_m98_sof", sof_c, 1'b1);
    pos_c("c_m98", 0, 0);
`ifdef VTG_FRAME_CNT_EN
    chk("c_fc3", fc_c, 2'd3);
`endif
    adv_c(98);
    chk("c_m196_sof", sof_c, 1'b1);
`ifdef VTG_FRAME_CNT_EN
    chk("c_fc_wrap0", fc_c, 2'd0);
`endif
    adv_c(98);
    chk("c_m294_sof", sof_c, 1'b1);
`ifdef VTG_FRAME_CNT_EN
    chk("c_fc_wrap1", fc_c, 2'd1);
`endif
    adv_c(47);
    pos_c("c_m341", 5, 3);
    chk("c_m341_de", de_c, 1'b1);

    rst = 1'b0;
    @(negedge clk);
    chk_rst("c_mid", pce_c, x_c, y_c, de_c, hs_c, vs_c, sol_c, sof_c, busy_c, 1'b1, 1'b1);
`ifdef VTG_FRAME_CNT_EN
    chk("c_mid_fc", fc_c, 2'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("c_re_pce1", pce_c, 1'b0);
    @(negedge clk);
    chk("c_re_pce2", pce_c, 1'b1);
    chk("c_re_sof", sof_c, 1'b1);
    pos_c("c_re0", 0, 0);
`ifdef VTG_FRAME_CNT_EN
    chk("c_re_fc", fc_c, 2'd1);
`endif
    adv_c(97);
    pos_c("c_re97", 13, 6);
    chk("c_re97_sof", sof_c, 1'b0);
    adv_c(1);
    chk("c_re98_sof", sof_c, 1'b1);
    pos_c("c_re98", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
